// File: rtl/scan_dff_bank.sv
// scan_dff_bank: WIDTH D flip-flops with clock enable, CHAINS independent
// mux-scan chains of length L = WIDTH/CHAINS, and a shared shift counter
// that flags each completed L-bit load with a one-cycle DONE pulse.
module scan_dff_bank #(
    parameter int unsigned        WIDTH     = 8,
    parameter int unsigned        CHAINS    = 2,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0,
    localparam int unsigned       L         = WIDTH / CHAINS,
    localparam int unsigned       CW        = (L > 1) ? $clog2(L) : 1
) (
    input  logic              CLK,
    input  logic              R,
    input  logic              EN,
    input  logic              SE,
    input  logic [WIDTH-1:0]  D,
    input  logic [CHAINS-1:0] SI,
    output logic [WIDTH-1:0]  Q,
    output logic [WIDTH-1:0]  QN,
    output logic [CHAINS-1:0] SO,
    output logic [CW-1:0]     SHIFT_CNT,
    output logic              DONE
);

    // Reject configurations where the chains cannot evenly split the bank.
    if (CHAINS < 1) begin : g_bad_chains
        $error("scan_dff_bank: CHAINS must be at least 1");
    end
    if ((CHAINS >= 1) && (WIDTH % CHAINS != 0)) begin : g_bad_width
        $error("scan_dff_bank: WIDTH must be a multiple of CHAINS");
    end

    localparam logic [CW-1:0] CNT_LAST = CW'(L - 1);

    logic [WIDTH-1:0] q_q, q_d, q_shift;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             cnt_wrap;

    // Shifted image: each chain takes its SI at the low end and moves up one bit.
    always_comb begin
        q_shift = q_q;
        for (int c = 0; c < int'(CHAINS); c++) begin
            q_shift[c*L] = SI[c];
            for (int k = 1; k < int'(L); k++) begin
                q_shift[c*L+k] = q_q[c*L+k-1];
            end
        end
    end

    // Next state: shift beats capture beats hold; any non-shift edge abandons a load.
    always_comb begin
        cnt_wrap = (cnt_q == CNT_LAST);
        q_d      = q_q;
        cnt_d    = '0;
        done_d   = 1'b0;
        if (SE) begin
            q_d    = q_shift;
            cnt_d  = cnt_wrap ? '0 : cnt_q + 1'b1;
            done_d = cnt_wrap;
        end else if (EN) begin
            q_d = D;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge CLK or posedge R) begin
        if (R) begin
            q_q    <= RESET_VAL;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    // Scan-out taps the top bit of each chain: the bit leaving on the next shift.
    always_comb begin
        SO = '0;
        for (int c = 0; c < int'(CHAINS); c++) begin
            SO[c] = q_q[c*L+L-1];
        end
    end

    assign Q         = q_q;
    assign QN        = ~q_q;
    assign SHIFT_CNT = cnt_q;
    assign DONE      = done_q;

endmodule

// File: tb/tb_scan_dff_bank.sv
// tb_scan_dff_bank: directed checks of reset, capture/hold, scan load/unload,
// counter abort/restart and mid-load reset on an 8x2 bank, plus an L=1 bank.
module tb_scan_dff_bank;

    logic       clk;
    int         n_checks = 0;
    int         n_errors = 0;

    // Main bank: WIDTH=8, CHAINS=2, L=4, RESET_VAL=A5.
    logic       r, en, se;
    logic [7:0] d, q, qn;
    logic [1:0] si, so, cnt;
    logic       done;

    // L=1 bank: WIDTH=4, CHAINS=4.
    logic       r1, en1, se1;
    logic [3:0] d1, q1, qn1, si1, so1;
    logic       cnt1, done1;

    // Per-edge SI for the load: bit1 = chain1 (0,0,1,0), bit0 = chain0 (1,0,1,1).
    logic [1:0] si_seq [4] = '{2'b01, 2'b00, 2'b11, 2'b01};
    // SO before each unload edge from Q=C3: chain1 1,1,0,0 and chain0 0,0,1,1.
    logic [1:0] so_seq [4] = '{2'b10, 2'b10, 2'b01, 2'b01};

    scan_dff_bank #(
        .WIDTH     (8),
        .CHAINS    (2),
        .RESET_VAL (8'hA5)
    ) u_dut (
        .CLK       (clk),
        .R         (r),
        .EN        (en),
        .SE        (se),
        .D         (d),
        .SI        (si),
        .Q         (q),
        .QN        (qn),
        .SO        (so),
        .SHIFT_CNT (cnt),
        .DONE      (done)
    );

    scan_dff_bank #(
        .WIDTH     (4),
        .CHAINS    (4),
        .RESET_VAL (4'h0)
    ) u_dut_l1 (
        .CLK       (clk),
        .R         (r1),
        .EN        (en1),
        .SE        (se1),
        .D         (d1),
        .SI        (si1),
        .Q         (q1),
        .QN        (qn1),
        .SO        (so1),
        .SHIFT_CNT (cnt1),
        .DONE      (done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One rising edge, then settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        r = 1'b1; en = 1'b0; se = 1'b0; d = '0; si = '0;
        r1 = 1'b1; en1 = 1'b0; se1 = 1'b0; d1 = '0; si1 = '0;
        tick();
        tick();
        check("reset_q", 32'(q), 32'h0A5);
        r = 1'b0; r1 = 1'b0;

        // 1: async reset with no clock edge, and edges ignored while held
        en = 1'b1; d = 8'h11;
        tick();
        check("pre_reset_q", 32'(q), 32'h011);
        #2 r = 1'b1;
        #1;
        check("async_q", 32'(q), 32'h0A5);
        check("async_qn", 32'(qn), 32'h05A);
        check("async_cnt", 32'(cnt), 32'd0);
        check("async_done", 32'(done), 32'd0);
        d = 8'hFF;
        tick();
        tick();
        check("held_reset_q", 32'(q), 32'h0A5);
        r = 1'b0;

        // 2: capture then hold
        en = 1'b1; d = 8'h3C;
        tick();
        check("capture_q", 32'(q), 32'h03C);
        check("capture_qn", 32'(qn), 32'h0C3);
        en = 1'b0; d = 8'hFF;
        repeat (3) tick();
        check("hold_q", 32'(q), 32'h03C);

        // 3: scan load from 00 with D ignored
        en = 1'b1; d = 8'h00;
        tick();
        se = 1'b1; d = 8'hFF;
        for (int i = 0; i < 4; i++) begin
            si = si_seq[i];
            tick();
            check("load_cnt", 32'(cnt), 32'((i + 1) % 4));
            check("load_done", 32'(done), (i == 3) ? 32'd1 : 32'd0);
        end
        // chain0 = 1011, chain1 = 0010
        check("load_q", 32'(q), 32'h02B);
        se = 1'b0; en = 1'b0;
        tick();
        check("load_done_clear", 32'(done), 32'd0);
        check("load_cnt_clear", 32'(cnt), 32'd0);

        // 4: unload C3 with zeros shifted in
        en = 1'b1; d = 8'hC3;
        tick();
        en = 1'b0; se = 1'b1; si = 2'b00;
        for (int i = 0; i < 4; i++) begin
            check("unload_so", 32'(so), 32'(so_seq[i]));
            tick();
        end
        check("unload_q", 32'(q), 32'h000);
        check("unload_done", 32'(done), 32'd1);

        // 5: abort a partial load, then a full one
        se = 1'b0;
        tick();
        se = 1'b1; si = 2'b11;
        tick();
        tick();
        check("abort_cnt_mid", 32'(cnt), 32'd2);
        se = 1'b0;
        tick();
        check("abort_cnt", 32'(cnt), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_q_hold", 32'(q), 32'h033);
        se = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("restart_done", 32'(done), (i == 3) ? 32'd1 : 32'd0);
        end
        check("restart_cnt", 32'(cnt), 32'd0);

        // 6: reset mid-load discards it
        se = 1'b0;
        tick();
        se = 1'b1; si = 2'b01;
        repeat (3) tick();
        check("midload_cnt", 32'(cnt), 32'd3);
        #2 r = 1'b1;
        #1;
        check("midload_rst_cnt", 32'(cnt), 32'd0);
        check("midload_rst_q", 32'(q), 32'h0A5);
        tick();
        r = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("reload_done", 32'(done), (i == 3) ? 32'd1 : 32'd0);
        end
        // DONE high, then cleared by reset without an edge
        #2 r = 1'b1;
        #1;
        check("done_async_clear", 32'(done), 32'd0);
        tick();
        r = 1'b0; se = 1'b0;

        // L=1: every shift edge completes a load
        se1 = 1'b1; si1 = 4'hA;
        tick();
        check("l1_q_a", 32'(q1), 32'h00A);
        check("l1_so_a", 32'(so1), 32'h00A);
        check("l1_done_a", 32'(done1), 32'd1);
        check("l1_cnt_a", 32'(cnt1), 32'd0);
        si1 = 4'h5;
        tick();
        check("l1_q_5", 32'(q1), 32'h005);
        check("l1_done_5", 32'(done1), 32'd1);
        check("l1_cnt_5", 32'(cnt1), 32'd0);
        se1 = 1'b0; en1 = 1'b0;
        tick();
        check("l1_done_off", 32'(done1), 32'd0);
        check("l1_hold_q", 32'(q1), 32'h005);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
